// File: rtl/flag_sequencer.sv
//-----------------------------------------------------------------------------
// flag_sequencer
//
// Selects one of NUM_FLAGS flag colour streams for the VGA pixel path.
// Flag changes take effect only at frame boundaries. A change can come from a
// manual select, a next/prev step or the auto-advance timer.
//
// Optional feature macro: FLAG_SEQ_WIPE_EN
//   defined   : a flag change is shown as a left-to-right wipe. The wipe edge
//               advances WIPE_STEP pixels per frame until it reaches H_ACTIVE.
//   undefined : a flag change is instant at frame_start. busy is tied to 0.
//
// Ports
//   clk          pixel clock
//   rst          asynchronous reset, active-high
//   frame_start  one-cycle pulse at the start of each frame
//   pix_x        current pixel column
//   pix_y        current pixel row (unused; kept for generator parity)
//   flag_colors  flag i colour at bits [i*COLOR_W +: COLOR_W]
//   manual_sel   requested flag index (ignored if >= NUM_FLAGS)
//   manual_valid one-cycle strobe: request manual_sel
//   step_next    one-cycle strobe: request target+1 (modulo NUM_FLAGS)
//   step_prev    one-cycle strobe: request target-1 (modulo NUM_FLAGS)
//   auto_en      enables the auto-advance timer
//   color        registered output colour
//   cur_index    flag currently shown / being wiped in
//   count        constant NUM_FLAGS
//   busy         high while a wipe is in progress
//-----------------------------------------------------------------------------
module flag_sequencer #(
    parameter int NUM_FLAGS       = 8,
    parameter int COLOR_W         = 6,
    parameter int FRAMES_PER_FLAG = 180,
    parameter int H_ACTIVE        = 640,
    parameter int WIPE_STEP       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic [9:0]                   pix_x,
    input  logic [9:0]                   pix_y,
    input  logic [NUM_FLAGS*COLOR_W-1:0] flag_colors,
    input  logic [7:0]                   manual_sel,
    input  logic                         manual_valid,
    input  logic                         step_next,
    input  logic                         step_prev,
    input  logic                         auto_en,
    output logic [COLOR_W-1:0]           color,
    output logic [7:0]                   cur_index,
    output logic [7:0]                   count,
    output logic                         busy
);

    localparam int             TW         = (FRAMES_PER_FLAG > 1) ? $clog2(FRAMES_PER_FLAG) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(FRAMES_PER_FLAG - 1);
    localparam logic [7:0]     LAST_IDX   = 8'(NUM_FLAGS - 1);

    logic              pend_valid, pend_valid_d;
    logic [7:0]        pend_tgt, pend_tgt_d;
    logic [7:0]        cur_d;
    logic [TW-1:0]     timer, timer_d;
    logic [COLOR_W-1:0] color_d;
    logic [7:0]        base_idx, next_idx, prev_idx, sel_idx;
    logic              manual_ok, idle, auto_req;

`ifdef FLAG_SEQ_WIPE_EN
    localparam int WPW = $clog2(H_ACTIVE + WIPE_STEP + 1);
    localparam int CW  = (WPW > 10) ? WPW : 10;

    typedef enum logic {IDLE, WIPE} state_t;

    state_t          state, state_d;
    logic [7:0]      old_idx, old_d;
    logic [WPW-1:0]  wipe_pos, wipe_d;

    logic unused_pix;
    assign unused_pix = ^pix_y;
    assign idle       = (state == IDLE);
    assign busy       = (state == WIPE);
`else
    logic unused_pix;
    assign unused_pix = ^{pix_x, pix_y};
    assign idle       = 1'b1;
    assign busy       = 1'b0;
`endif

    assign count = 8'(NUM_FLAGS);

    // Steps are taken from the pending target so back-to-back steps accumulate.
    assign base_idx  = pend_valid ? pend_tgt : cur_index;
    assign next_idx  = (base_idx == LAST_IDX) ? 8'd0 : base_idx + 8'd1;
    assign prev_idx  = (base_idx == 8'd0) ? LAST_IDX : base_idx - 8'd1;
    assign manual_ok = ({1'b0, manual_sel} < 9'(NUM_FLAGS));

    // The timer raises its request as soon as it sits at the last count, so the
    // switch lands on the following frame_start: one flag per FRAMES_PER_FLAG
    // frames.
    assign auto_req  = auto_en && idle && !pend_valid && (timer == TIMER_LAST);

    always_comb begin
        pend_valid_d = pend_valid;
        pend_tgt_d   = pend_tgt;
        cur_d        = cur_index;
        timer_d      = timer;
        sel_idx      = cur_index;
`ifdef FLAG_SEQ_WIPE_EN
        state_d      = state;
        old_d        = old_idx;
        wipe_d       = wipe_pos;
`endif

        if (auto_req) begin
            timer_d = '0;
        end else if (frame_start && auto_en && idle && !pend_valid) begin
            timer_d = timer + 1'b1;
        end

        if (frame_start && idle && pend_valid) begin
            pend_valid_d = 1'b0;
            if (pend_tgt != cur_index) begin
                cur_d   = pend_tgt;
                timer_d = '0;
`ifdef FLAG_SEQ_WIPE_EN
                old_d   = cur_index;
                wipe_d  = WPW'(WIPE_STEP);
                state_d = WIPE;
`endif
            end
        end
`ifdef FLAG_SEQ_WIPE_EN
        else if (frame_start && state == WIPE) begin
            if (wipe_pos + WPW'(WIPE_STEP) >= WPW'(H_ACTIVE)) begin
                wipe_d  = '0;
                state_d = IDLE;
            end else begin
                wipe_d  = wipe_pos + WPW'(WIPE_STEP);
            end
        end
`endif

        // New captures come after the apply so a request arriving with
        // frame_start survives into the next frame.
        if (manual_valid) begin
            if (manual_ok) begin
                pend_valid_d = 1'b1;
                pend_tgt_d   = manual_sel;
            end
        end else if (step_next) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = next_idx;
        end else if (step_prev) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = prev_idx;
        end else if (auto_req) begin
            pend_valid_d = 1'b1;
            pend_tgt_d   = next_idx;
        end

`ifdef FLAG_SEQ_WIPE_EN
        if (state == WIPE && CW'(pix_x) >= CW'(wipe_pos)) begin
            sel_idx = old_idx;
        end
`endif
        color_d = flag_colors[sel_idx*COLOR_W +: COLOR_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color      <= '0;
            cur_index  <= '0;
            pend_valid <= 1'b0;
            pend_tgt   <= '0;
            timer      <= '0;
        end else begin
            color      <= color_d;
            cur_index  <= cur_d;
            pend_valid <= pend_valid_d;
            pend_tgt   <= pend_tgt_d;
            timer      <= timer_d;
        end
    end

`ifdef FLAG_SEQ_WIPE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            old_idx  <= '0;
            wipe_pos <= '0;
        end else begin
            state    <= state_d;
            old_idx  <= old_d;
            wipe_pos <= wipe_d;
        end
    end
`endif

endmodule

// File: tb/tb_flag_sequencer.sv
//-----------------------------------------------------------------------------
// tb_flag_sequencer
//
// Directed bench for flag_sequencer with NUM_FLAGS=8, FRAMES_PER_FLAG=3,
// H_ACTIVE=640, WIPE_STEP=160. Flag i drives the constant colour i+1.
// Inputs change and outputs are sampled on the falling clock edge.
//-----------------------------------------------------------------------------
module tb_flag_sequencer;

    localparam int NF = 8;
    localparam int CW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic [NF*CW-1:0]  flag_colors;
    logic [7:0]        manual_sel;
    logic              manual_valid;
    logic              step_next;
    logic              step_prev;
    logic              auto_en;
    logic [CW-1:0]     color;
    logic [7:0]        cur_index;
    logic [7:0]        count;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flag_sequencer #(
        .NUM_FLAGS      (NF),
        .COLOR_W        (CW),
        .FRAMES_PER_FLAG(3),
        .H_ACTIVE       (640),
        .WIPE_STEP      (160)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .flag_colors  (flag_colors),
        .manual_sel   (manual_sel),
        .manual_valid (manual_valid),
        .step_next    (step_next),
        .step_prev    (step_prev),
        .auto_en      (auto_en),
        .color        (color),
        .cur_index    (cur_index),
        .count        (count),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle pulse of any combination of request strobes and frame_start.
    task automatic req(input logic mv, input logic [7:0] ms, input logic sn,
                       input logic sp, input logic fs);
        @(negedge clk);
        manual_valid = mv;
        manual_sel   = ms;
        step_next    = sn;
        step_prev    = sp;
        frame_start  = fs;
        @(negedge clk);
        manual_valid = 1'b0;
        step_next    = 1'b0;
        step_prev    = 1'b0;
        frame_start  = 1'b0;
    endtask

    task automatic frame();
        repeat (3) @(negedge clk);
        req(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Present a column and check the registered colour one clock later.
    task automatic check_pix(input string tag, input logic [9:0] x, input logic [CW-1:0] exp);
        @(negedge clk);
        pix_x = x;
        @(negedge clk);
        check(tag, 32'(color), 32'(exp));
    endtask

    // Runs frames until any wipe has finished; instant builds never wait.
    task automatic settle();
        int n = 0;
        while (busy && n < 10) begin
            frame();
            n++;
        end
        check("settle_not_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        frame_start  = 1'b0;
        pix_x        = '0;
        pix_y        = '0;
        manual_sel   = '0;
        manual_valid = 1'b0;
        step_next    = 1'b0;
        step_prev    = 1'b0;
        auto_en      = 1'b0;
        for (int i = 0; i < NF; i++) flag_colors[i*CW +: CW] = CW'(i + 1);

        repeat (2) @(negedge clk);
        check("reset_color", 32'(color), 32'd0);
        check("reset_index", 32'(cur_index), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        check("count",       32'(count), 32'd8);
        rst = 1'b0;

        frame();
        frame();
        check("idle_index", 32'(cur_index), 32'd0);
        check_pix("idle_pix0",   10'd0,   6'd1);
        check_pix("idle_pix639", 10'd639, 6'd1);

        // prev wraps 0 -> 7, next wraps 7 -> 0
        req(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        check("pending_no_change", 32'(cur_index), 32'd0);
        frame();
        check("prev_wrap", 32'(cur_index), 32'd7);
`ifndef FLAG_SEQ_WIPE_EN
        check("instant_busy", 32'(busy), 32'd0);
`endif
        settle();
        check_pix("prev_wrap_pix", 10'd300, 6'd8);
        req(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        frame();
        check("next_wrap", 32'(cur_index), 32'd0);
        settle();

        // out-of-range manual select is ignored
        req(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
        frame();
        check("manual_oob", 32'(cur_index), 32'd0);

        // manual beats step_next in the same cycle
        req(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
        frame();
        check("manual_prio", 32'(cur_index), 32'd5);
        settle();

        // request coinciding with frame_start waits one frame
        req(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        check("same_cycle_wait", 32'(cur_index), 32'd5);
        frame();
        check("same_cycle_apply", 32'(cur_index), 32'd6);
        settle();

        // two steps accumulate on the pending target: 6 -> 7 -> 0
        req(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        req(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        frame();
        check("step_accumulate", 32'(cur_index), 32'd0);
        settle();

`ifndef FLAG_SEQ_WIPE_EN
        // auto-advance every 3rd frame_start, wrapping 7 -> 0
        req(1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
        frame();
        check("auto_start", 32'(cur_index), 32'd6);
        auto_en = 1'b1;
        frame(); check("auto_f1", 32'(cur_index), 32'd6);
        frame(); check("auto_f2", 32'(cur_index), 32'd6);
        frame(); check("auto_f3", 32'(cur_index), 32'd7);
        frame(); check("auto_f4", 32'(cur_index), 32'd7);
        frame(); check("auto_f5", 32'(cur_index), 32'd7);
        frame(); check("auto_f6", 32'(cur_index), 32'd0);
        auto_en = 1'b0;
        frame(); frame(); frame();
        check("auto_hold", 32'(cur_index), 32'd0);
        check_pix("auto_pix", 10'd10, 6'd1);

        req(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        frame();
        check_pix("pre_reset_pix", 10'd20, 6'd4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_color", 32'(color), 32'd0);
        check("async_rst_index", 32'(cur_index), 32'd0);
        check("async_rst_busy",  32'(busy), 32'd0);
`else
        // wipe 0 -> 2: edge at 160, 320, 480, then idle
        req(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        frame();
        check("wipe_busy0",  32'(busy), 32'd1);
        check("wipe_index0", 32'(cur_index), 32'd2);
        check_pix("wipe_f1_159", 10'd159, 6'd3);
        check_pix("wipe_f1_160", 10'd160, 6'd1);
        frame();
        check_pix("wipe_f2_319", 10'd319, 6'd3);
        check_pix("wipe_f2_320", 10'd320, 6'd1);
        req(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        frame();
        check("wipe_busy3", 32'(busy), 32'd1);
        frame();
        check("wipe_done_busy",  32'(busy), 32'd0);
        check("wipe_done_index", 32'(cur_index), 32'd2);
        check_pix("wipe_done_pix", 10'd600, 6'd3);
        frame();
        check("mid_wipe_req_index", 32'(cur_index), 32'd3);
        check("mid_wipe_req_busy",  32'(busy), 32'd1);
        check_pix("pre_reset_pix", 10'd0, 6'd4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_color", 32'(color), 32'd0);
        check("async_rst_index", 32'(cur_index), 32'd0);
        check("async_rst_busy",  32'(busy), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
